// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: FSM state encoding and local register map.
package irq_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] CLR  = 2'd2;

    localparam logic [7:0] IRQ_MASK_A   = 8'h00;
    localparam logic [7:0] IRQ_PEND_A   = 8'h01;
    localparam logic [7:0] IRQ_STAT_A   = 8'h02;
    localparam logic [7:0] IRQ_SWTRIG_A = 8'h03;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports whether any source is pending and the lowest set index.
module irq_prio_enc #(
    parameter int N_SRC = 8,
    parameter int VEC_W = 3
) (
    input  logic [N_SRC-1:0] pending,
    output logic             valid,
    output logic [VEC_W-1:0] index
);

    always_comb begin
        valid = |pending;
        index = '0;
        // Walk from the top down so the lowest set bit is the last one written.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pending[i]) begin
                index = VEC_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Masked, prioritised interrupt controller with acknowledge-driven flag clear.
// Optional software trigger register is built when IRQ_SW_TRIGGER_EN is defined.
//
//  state | meaning
//  IDLE  | no request outstanding; arbitrate pending each cycle
//  REQ   | irq_req high, irq_vec frozen; wait for ack or withdrawal
//  CLR   | one-cycle irq_clr pulse so the source flag falls before re-arbitration
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int N_SRC = 8,
    parameter int VEC_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       din,
    input  logic [7:0]       address,
    input  logic             w_en,
    input  logic             r_en,
    output logic [7:0]       dout,
    input  logic [N_SRC-1:0] irq_src,
    output logic [N_SRC-1:0] irq_clr,
    output logic             irq_req,
    output logic [VEC_W-1:0] irq_vec,
    input  logic             irq_ack
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] pending;
    logic             win_valid;
    logic [VEC_W-1:0] win_idx;
    logic             ack_take;
    logic             withdraw;
    logic             req_nxt;
    logic             vec_load;
    logic [N_SRC-1:0] clr_nxt;
    logic [7:0]       rd_data;
    logic             rd_hit;

    irq_prio_enc #(
        .N_SRC (N_SRC),
        .VEC_W (VEC_W)
    ) u_prio_enc (
        .pending (pending),
        .valid   (win_valid),
        .index   (win_idx)
    );

    assign ack_take = (state == REQ) && irq_ack;
    assign withdraw = (state == REQ) && !irq_ack && !pending[irq_vec];

`ifdef IRQ_SW_TRIGGER_EN
    logic [N_SRC-1:0] swtrig;

    always_ff @(posedge clk) begin
        if (rst) begin
            swtrig <= '0;
        end else begin
            if (w_en && address == IRQ_SWTRIG_A) begin
                swtrig <= din[N_SRC-1:0];
            end
            // Self-clear comes second so it beats a same-cycle firmware write for this bit only.
            if (ack_take) begin
                swtrig[irq_vec] <= 1'b0;
            end
        end
    end

    assign pending = (irq_src & mask) | swtrig;
`else
    assign pending = irq_src & mask;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_valid) state_nxt = REQ;
            REQ:     if (ack_take) state_nxt = CLR;
                     else if (withdraw) state_nxt = IDLE;
            CLR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_nxt  = (state_nxt == REQ);
        vec_load = (state == IDLE) && win_valid;
        clr_nxt  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            clr_nxt[i] = (state_nxt == CLR) && (irq_vec == VEC_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_req <= 1'b0;
            irq_vec <= '0;
            irq_clr <= '0;
        end else begin
            irq_req <= req_nxt;
            irq_clr <= clr_nxt;
            if (vec_load) begin
                irq_vec <= win_idx;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_hit  = 1'b1;
        case (address)
            IRQ_MASK_A: rd_data[N_SRC-1:0] = mask;
            IRQ_PEND_A: rd_data[N_SRC-1:0] = pending;
            IRQ_STAT_A: begin
                rd_data[7]         = irq_req;
                rd_data[VEC_W-1:0] = irq_vec;
            end
`ifdef IRQ_SW_TRIGGER_EN
            IRQ_SWTRIG_A: rd_data[N_SRC-1:0] = swtrig;
`else
            IRQ_SWTRIG_A: rd_data = '0;
`endif
            default: rd_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask <= '0;
            dout <= '0;
        end else begin
            if (w_en && address == IRQ_MASK_A) begin
                mask <= din[N_SRC-1:0];
            end
            if (r_en && rd_hit) begin
                dout <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios followed by random traffic against a cycle-level reference model.
module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic [7:0] address;
    logic       w_en;
    logic       r_en;
    logic [7:0] dout;
    logic [7:0] irq_src;
    logic [7:0] irq_clr;
    logic       irq_req;
    logic [2:0] irq_vec;
    logic       irq_ack;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: what the controller should be showing after each edge.
    logic [7:0] m_mask;
    logic [7:0] m_sw;
    logic [7:0] m_dout;
    logic       m_req;
    logic [2:0] m_vec;
    logic [7:0] m_clr;

    always #5 clk = ~clk;

    irq_ctrl #(
        .N_SRC (8),
        .VEC_W (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .address (address),
        .w_en    (w_en),
        .r_en    (r_en),
        .dout    (dout),
        .irq_src (irq_src),
        .irq_clr (irq_clr),
        .irq_req (irq_req),
        .irq_vec (irq_vec),
        .irq_ack (irq_ack)
    );

    function automatic logic [2:0] lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [7:0] pend;
        logic [7:0] nm, nsw, nd, nclr;
        logic       nreq;
        logic [2:0] nvec;
        pend = (irq_src & m_mask) | m_sw;
        if (rst) begin
            m_mask = 8'h00; m_sw = 8'h00; m_dout = 8'h00;
            m_req  = 1'b0;  m_vec = 3'd0; m_clr = 8'h00;
        end else begin
            nm = m_mask; nsw = m_sw; nd = m_dout; nreq = m_req; nvec = m_vec; nclr = 8'h00;
            if (w_en && address == 8'h00) nm = din;
`ifdef IRQ_SW_TRIGGER_EN
            if (w_en && address == 8'h03) nsw = din;
`endif
            if (r_en) begin
                case (address)
                    8'h00: nd = m_mask;
                    8'h01: nd = pend;
                    8'h02: nd = {m_req, 4'b0000, m_vec};
                    8'h03: nd = m_sw;
                    default: ;
                endcase
            end
            if (m_clr != 8'h00) begin
                nreq = 1'b0;
            end else if (!m_req) begin
                if (pend != 8'h00) begin
                    nreq = 1'b1;
                    nvec = lowest(pend);
                end
            end else if (irq_ack) begin
                nreq = 1'b0;
                nclr = 8'h01 << m_vec;
                nsw[m_vec] = 1'b0;
            end else if (!pend[m_vec]) begin
                nreq = 1'b0;
            end
            m_mask = nm; m_sw = nsw; m_dout = nd; m_req = nreq; m_vec = nvec; m_clr = nclr;
        end
    endtask

    // One clock: model follows the edge, outputs checked 1 time unit later,
    // then sources drop any flag that received a clear pulse.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model_irq_req", 32'(irq_req), 32'(m_req));
        chk("model_irq_vec", 32'(irq_vec), 32'(m_vec));
        chk("model_irq_clr", 32'(irq_clr), 32'(m_clr));
        chk("model_dout",    32'(dout),    32'(m_dout));
        irq_src = irq_src & ~irq_clr;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        address = a; din = d; w_en = 1'b1;
        tick();
        w_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        address = a; r_en = 1'b1;
        tick();
        r_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; din = 8'h00; address = 8'h00; w_en = 1'b0; r_en = 1'b0;
        irq_src = 8'h00; irq_ack = 1'b0;
        m_mask = 8'h00; m_sw = 8'h00; m_dout = 8'h00; m_req = 1'b0; m_vec = 3'd0; m_clr = 8'h00;

        tick();
        tick();
        chk("reset_req", 32'(irq_req), 32'd0);
        chk("reset_vec", 32'(irq_vec), 32'd0);
        chk("reset_clr", 32'(irq_clr), 32'd0);
        chk("reset_dout", 32'(dout), 32'd0);
        rst = 1'b0;

        // Single source, request and acknowledge.
        wr(8'h00, 8'h01);
        irq_src = 8'h01;
        tick();
        chk("t1_req", 32'(irq_req), 32'd1);
        chk("t1_vec", 32'(irq_vec), 32'd0);
        irq_ack = 1'b1;
        tick();
        chk("t1_clr", 32'(irq_clr), 32'h01);
        chk("t1_req_drop", 32'(irq_req), 32'd0);
        irq_ack = 1'b0;
        tick();
        chk("t1_clr_once", 32'(irq_clr), 32'h00);

        // Two sources together: priority, then back-to-back spacing.
        wr(8'h00, 8'h07);
        irq_src = 8'h06;
        tick();
        chk("t2_vec_first", 32'(irq_vec), 32'd1);
        irq_ack = 1'b1;
        tick();
        chk("t2_clr", 32'(irq_clr), 32'h02);
        irq_ack = 1'b0;
        tick();
        chk("t2_gap_idle", 32'(irq_req), 32'd0);
        tick();
        chk("t2_req_second", 32'(irq_req), 32'd1);
        chk("t2_vec_second", 32'(irq_vec), 32'd2);
        rd(8'h02);
        chk("t2_status", 32'(dout), 32'h82);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        tick();

        // Masking off the active vector withdraws the request with no pulse.
        irq_src = 8'h04;
        wr(8'h00, 8'h04);
        chk("t3_req", 32'(irq_req), 32'd1);
        wr(8'h00, 8'h00);
        chk("t3_req_hold", 32'(irq_req), 32'd1);
        tick();
        chk("t3_withdrawn", 32'(irq_req), 32'd0);
        chk("t3_no_clr", 32'(irq_clr), 32'h00);
        irq_src = 8'h00;
        tick();

        // Ack and withdrawal in the same cycle: ack wins.
        wr(8'h00, 8'h01);
        irq_src = 8'h01;
        tick();
        chk("t4_req", 32'(irq_req), 32'd1);
        irq_src = 8'h00;
        irq_ack = 1'b1;
        tick();
        chk("t4_clr", 32'(irq_clr), 32'h01);
        irq_ack = 1'b0;
        tick();

        // Reset in the middle of a request.
        irq_src = 8'h01;
        tick();
        rd(8'h00);
        chk("t5_req", 32'(irq_req), 32'd1);
        chk("t5_mask_before", 32'(dout), 32'h01);
        rst = 1'b1;
        tick();
        chk("t5_req_drop", 32'(irq_req), 32'd0);
        chk("t5_no_clr", 32'(irq_clr), 32'h00);
        chk("t5_dout_reset", 32'(dout), 32'h00);
        rst = 1'b0;
        irq_src = 8'h00;
        rd(8'h00);
        chk("t5_mask_read", 32'(dout), 32'h00);
        chk("t5_no_clr_after", 32'(irq_clr), 32'h00);

        // Software trigger.
        wr(8'h00, 8'h08);
        wr(8'h03, 8'h08);
`ifdef IRQ_SW_TRIGGER_EN
        chk("t6_not_yet", 32'(irq_req), 32'd0);
        tick();
        chk("t6_req", 32'(irq_req), 32'd1);
        chk("t6_vec", 32'(irq_vec), 32'd3);
        irq_ack = 1'b1;
        tick();
        chk("t6_clr", 32'(irq_clr), 32'h08);
        irq_ack = 1'b0;
        rd(8'h03);
        chk("t6_swtrig_cleared", 32'(dout), 32'h00);
`else
        tick();
        tick();
        chk("t6_no_req", 32'(irq_req), 32'd0);
        rd(8'h03);
        chk("t6_swtrig_reads0", 32'(dout), 32'h00);
`endif
        wr(8'h00, 8'h00);
        wr(8'h03, 8'h00);

        // Random traffic checked against the model every cycle.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(0, 299) == 0);
            irq_src = irq_src | 8'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) irq_src = irq_src & 8'($urandom);
            irq_ack = ($urandom_range(0, 2) == 0);
            w_en = ($urandom_range(0, 9) == 0);
            r_en = ($urandom_range(0, 2) == 0);
            address = 8'($urandom_range(0, 5));
            if (w_en && $urandom_range(0, 1) == 0) address = 8'h00;
            din = 8'($urandom);
            tick();
        end
        rst = 1'b0; w_en = 1'b0; r_en = 1'b0; irq_ack = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
